// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned ADDR_W_DEF = 5;

  // Clear-sweep controller states
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback and the register file.
//   master: drives read addresses, both write lanes and clr_req
//   slave : returns read data, clr_busy and the wr_conflict/wr_drop pulses
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     wr_conflict;
  logic                     wr_drop;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, clr_req,
    input  rd_data, clr_busy, wr_conflict, wr_drop
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data, clr_req,
    output rd_data, clr_busy, wr_conflict, wr_drop
  );

endinterface

// File: rtl/regfile_clear_ctrl.sv
// Clear-sweep controller: walks ptr over every entry once per clr_req.
//   clr_req  : start request (ignored while sweeping)
//   clr_busy : registered, high for the whole sweep
//   clr_we   : entry clr_addr is zeroed on this edge
//   clr_addr : entry being cleared
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;

  // Next state; ptr wraps naturally to 0 after the last entry
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    clr_we   = 1'b0;
    clr_addr = ptr_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign clr_busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write lanes (lane 1 wins on same address),
// NUM_RD combinational read ports with optional bypass and hardwired zero,
// asynchronous reset of all entries and a sequential clear sweep.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : read ports, write lanes, clear request and status flags
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              clr_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic wr0_ok, wr1_ok, byp_en;
  logic conflict_q, conflict_d;
  logic drop_q, drop_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;

  regfile_clear_ctrl #(.ADDR_W(ADDR_W)) u_clear_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A lane write is meaningful unless it targets the hardwired zero entry
  assign wr0_ok = bus.wr0_en && !((ZERO_REG != 0) && (bus.wr0_addr == '0));
  assign wr1_ok = bus.wr1_en && !((ZERO_REG != 0) && (bus.wr1_addr == '0));
  assign byp_en = (BYPASS != 0) && !clr_busy;

  // Array update: the sweep owns the array; otherwise lane 1 is applied last
  always_comb begin
    mem_d = mem_q;
    if (clr_we) begin
      mem_d[clr_addr] = '0;
    end else begin
      if (wr0_ok) mem_d[bus.wr0_addr] = bus.wr0_data;
      if (wr1_ok) mem_d[bus.wr1_addr] = bus.wr1_data;
    end
  end

  assign conflict_d = !clr_busy && wr0_ok && wr1_ok && (bus.wr0_addr == bus.wr1_addr);
  assign drop_d     = clr_busy && (wr0_ok || wr1_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      conflict_q <= conflict_d;
      drop_q     <= drop_d;
    end
  end

  // Per-port read mux: array, then bypass (lane 1 over lane 0), then zero
  for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr_c;
    logic [DATA_W-1:0] rd_word_c;

    assign rd_addr_c = bus.rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      rd_word_c = mem_q[rd_addr_c];
      if (byp_en && wr0_ok && (bus.wr0_addr == rd_addr_c)) rd_word_c = bus.wr0_data;
      if (byp_en && wr1_ok && (bus.wr1_addr == rd_addr_c)) rd_word_c = bus.wr1_data;
      if ((ZERO_REG != 0) && (rd_addr_c == '0))            rd_word_c = '0;
    end

    assign rd_data_c[g*DATA_W +: DATA_W] = rd_word_c;
  end

  assign bus.rd_data     = rd_data_c;
  assign bus.clr_busy    = clr_busy;
  assign bus.wr_conflict = conflict_q;
  assign bus.wr_drop     = drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic, all
// compared against an array-based reference of the register file rules.
module tb_regfile_mp;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int          DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            ref_busy;
  int            ref_ptr;
  bit            ref_conf;
  bit            ref_drop;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_busy = 0;
    ref_ptr  = 0;
    ref_conf = 0;
    ref_drop = 0;
  endtask

  // Expected value of a read given the inputs currently presented
  function automatic logic [DW-1:0] ref_read(logic [AW-1:0] a);
    if (a == '0) return '0;
    if (!ref_busy && bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
    if (!ref_busy && bus.wr0_en && bus.wr0_addr == a) return bus.wr0_data;
    return ref_mem[a];
  endfunction

  // Apply one rising edge to the reference
  task automatic ref_edge();
    bit w0, w1;
    w0 = bus.wr0_en && (bus.wr0_addr != '0);
    w1 = bus.wr1_en && (bus.wr1_addr != '0);
    ref_conf = !ref_busy && w0 && w1 && (bus.wr0_addr == bus.wr1_addr);
    ref_drop = ref_busy && (w0 || w1);
    if (ref_busy) begin
      ref_mem[ref_ptr] = '0;
      ref_ptr++;
      if (ref_ptr == DEPTH) begin
        ref_busy = 0;
        ref_ptr  = 0;
      end
    end else begin
      if (w0) ref_mem[bus.wr0_addr] = bus.wr0_data;
      if (w1) ref_mem[bus.wr1_addr] = bus.wr1_data;
      if (bus.clr_req) begin
        ref_busy = 1;
        ref_ptr  = 0;
      end
    end
  endtask

  task automatic check_reads(string tag);
    for (int i = 0; i < int'(NR); i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] got;
      a   = bus.rd_addr[i*AW +: AW];
      got = bus.rd_data[i*DW +: DW];
      check_val({tag, "_rd"}, got, ref_read(a));
    end
  endtask

  task automatic check_flags(string tag);
    check_val({tag, "_busy"}, 64'(bus.clr_busy), 64'(ref_busy));
    check_val({tag, "_conflict"}, 64'(bus.wr_conflict), 64'(ref_conf));
    check_val({tag, "_drop"}, 64'(bus.wr_drop), 64'(ref_drop));
  endtask

  // Entered 1 time unit after a rising edge with inputs already applied
  task automatic do_cycle(string tag);
    #1;
    check_reads(tag);
    @(posedge clk);
    ref_edge();
    #1;
    check_flags(tag);
  endtask

  task automatic set_idle();
    bus.wr0_en   = 1'b0;
    bus.wr1_en   = 1'b0;
    bus.wr0_addr = '0;
    bus.wr1_addr = '0;
    bus.wr0_data = '0;
    bus.wr1_data = '0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  // Sweep every address on both ports while idle, then resync to an edge
  task automatic read_all(string tag);
    set_idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(DEPTH - 1 - a));
      #1;
      check_reads(tag);
    end
    @(posedge clk);
    #1;
    ref_conf = 0;
    ref_drop = 0;
    check_flags(tag);
  endtask

  // Asynchronous reset pulse between edges
  task automatic do_reset(string tag);
    set_idle();
    rst_n = 1'b0;
    #2;
    ref_reset();
    check_flags({tag, "_async"});
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    ref_edge();
    #1;
    check_flags(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_idle();
    set_rd('0, '0);
    ref_reset();
    #12;
    check_flags("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_flags("post_reset");
    read_all("reset_rd");

    // Same-address conflict: lane 1 wins, visible by bypass then array
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 64'hAAAA;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd5; bus.wr1_data = 64'h5555;
    set_rd(5'd5, 5'd6);
    do_cycle("conflict_wr");
    set_idle();
    do_cycle("conflict_after");
    do_cycle("conflict_clear");

    // Hardwired zero entry
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 64'hFFFF;
    set_rd(5'd0, 5'd5);
    do_cycle("zero_wr");
    set_idle();
    do_cycle("zero_after");

    // Fill 1..31 with their index, then sweep
    for (int a = 1; a < DEPTH; a++) begin
      bus.wr0_en = 1'b1; bus.wr0_addr = AW'(a); bus.wr0_data = DW'(a);
      set_rd(AW'(a), AW'(a - 1));
      do_cycle("fill");
    end
    set_idle();
    bus.clr_req = 1'b1;
    do_cycle("clr_start");
    bus.clr_req = 1'b0;
    for (int k = 0; k < 40 && ref_busy; k++) begin
      set_idle();
      if (k == 10) set_rd(5'd9, 5'd20);
      else         set_rd(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      if (k == 12) begin
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd31; bus.wr0_data = 64'h1234;
        bus.clr_req = 1'b1;
        set_rd(5'd31, 5'd30);
      end
      do_cycle("sweep");
    end
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 64'hBEEF;
    set_rd(5'd3, 5'd31);
    do_cycle("post_sweep_wr");
    set_idle();
    do_cycle("post_sweep_rd");
    read_all("post_sweep_all");

    // Reset in the middle of a sweep, then a fresh full sweep
    for (int a = 1; a < DEPTH; a += 3) begin
      bus.wr0_en = 1'b1; bus.wr0_addr = AW'(a); bus.wr0_data = {$urandom, $urandom};
      do_cycle("refill");
    end
    set_idle();
    bus.clr_req = 1'b1;
    do_cycle("clr2_start");
    bus.clr_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_rd(AW'($urandom_range(0, 31)), AW'(k));
      do_cycle("sweep2");
    end
    do_reset("mid_sweep_reset");
    read_all("mid_reset_all");
    bus.clr_req = 1'b1;
    do_cycle("clr3_start");
    bus.clr_req = 1'b0;
    for (int k = 0; k < 40 && ref_busy; k++) begin
      set_rd(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      do_cycle("sweep3");
    end
    do_cycle("sweep3_done");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [AW-1:0] r0, r1;
      bus.wr0_en   = ($urandom_range(0, 2) != 0);
      bus.wr1_en   = ($urandom_range(0, 2) != 0);
      bus.wr0_addr = AW'($urandom_range(0, 31));
      bus.wr1_addr = ($urandom_range(0, 3) == 0) ? bus.wr0_addr : AW'($urandom_range(0, 31));
      bus.wr0_data = {$urandom, $urandom};
      bus.wr1_data = {$urandom, $urandom};
      bus.clr_req  = ($urandom_range(0, 60) == 0);
      r0 = ($urandom_range(0, 2) == 0) ? bus.wr0_addr : AW'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 2) == 0) ? bus.wr1_addr : AW'($urandom_range(0, 31));
      set_rd(r0, r1);
      if ($urandom_range(0, 400) == 0) do_reset("rand_reset");
      else                             do_cycle("rand");
    end
    set_idle();
    for (int k = 0; k < 40 && ref_busy; k++) do_cycle("drain");
    read_all("final_all");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next generation of the single-write, two-read 64×32 register file in the FPGA datapath. Adds a configurable read-port count, a second write port with defined same-address priority, optional hardwired-zero entry 0, optional write-to-read bypass, asynchronous reset of all entries, and a synchronous clear sweep controlled by a small FSM. It sits between decode (read addresses) and writeback (two retire lanes).

## Interface
- DATA_W, 64, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a read of an address written this cycle returns the incoming write data

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W]
- wr0_en, wr1_en  in  1 each  write enables, lane 0 and lane 1
- wr0_addr, wr1_addr  in  ADDR_W each  write addresses
- wr0_data, wr1_data  in  DATA_W each  write data
- clr_req  in  1  single-cycle request to start a clear sweep
- clr_busy  out  1  high while the sweep runs
- wr_conflict  out  1  registered; high for one cycle after both lanes wrote the same non-dropped address
- wr_drop  out  1  registered; high for one cycle after any enabled write was discarded due to a sweep

## Operation
- Write: on rising edge, each enabled lane stores its data at its address. Both lanes, same address: lane 1 wins; wr_conflict=1 next cycle.
- ZERO_REG=1: writes to address 0 are discarded silently (no wr_drop, no wr_conflict); reads of address 0 return 0 regardless of bypass.
- Read: combinational, rd_data[i] = entry[rd_addr[i]].
- BYPASS=1 and not clr_busy: if rd_addr[i] matches an enabled lane's address this cycle, return that lane's data; lane 1 has priority over lane 0. BYPASS=0: read returns the stored value (old data during a write cycle).
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clr_req=1 → SWEEP, ptr=0.
  - SWEEP: each cycle entry[ptr] <= 0, ptr++. At ptr == DEPTH-1 the entry is cleared and the FSM returns to IDLE; ptr wraps to 0.
  - clr_req in SWEEP is ignored (no restart, no queueing).
- During SWEEP, all enabled writes are dropped and wr_drop=1 next cycle. Reads return array contents: entries below ptr are already 0, the rest are untouched. Bypass is disabled.
- Reset (rst_n=0, any time, including mid-sweep): every entry 0, FSM IDLE, ptr 0, clr_busy=0, wr_conflict=0, wr_drop=0. rd_data then reflects zeroed entries, or bypass data if a write is presented.

## Timing
- Read latency 0 (combinational from rd_addr and array/bypass).
- Write latency: visible through the array on the cycle after the edge; visible in the same cycle via bypass.
- clr_busy rises on the edge that samples clr_req and stays high exactly DEPTH cycles. A write presented on the first cycle after clr_busy falls is accepted.
- wr_conflict and wr_drop are single-cycle pulses, registered, 1-cycle latency.
- Sweep length: DEPTH cycles (32 at defaults).

## Structure
- Package regfile_pkg holds the state enum (IDLE, SWEEP) and the default DATA_W and ADDR_W constants.
- Sub-module regfile_clear_ctrl contains the FSM and ptr counter. Outputs: clr_busy, clr_we, clr_addr.
- The top level holds the storage array, write-lane priority logic, the bypass/zero mux per read port (generate loop over NUM_RD), and the conflict/drop flags.

## Test plan
- Reset then read all 32 addresses on both ports → every rd_data = 0; clr_busy = 0, wr_conflict = 0, wr_drop = 0.
- wr0 addr 5 = 0xAAAA, wr1 addr 5 = 0x5555 in the same cycle, rd_addr0 = 5 → same-cycle bypass read 0x5555; next cycle reads 0x5555 from the array; wr_conflict = 1 for exactly one cycle.
- Write addr 0 = 0xFFFF with ZERO_REG=1 → read addr 0 returns 0 in the same cycle and the next; no flags raised.
- Fill entries 1..31 with their index, pulse clr_req → clr_busy high 32 cycles. After 10 cycles of busy, entries 0..9 read 0 and entry 20 reads 20. After busy falls, all entries read 0.
- During the sweep, wr0 addr 31 = 0x1234 → wr_drop pulses and entry 31 reads 0 after the sweep. A write on the first cycle after busy falls is stored.
- Assert rst_n low mid-sweep at ptr = 12 and release → FSM IDLE, clr_busy = 0, all entries 0; a following clr_req starts a fresh 32-cycle sweep.
